// File: rtl/vpu_uart_pkg.sv
// Shared constants and state encodings for the host UART command path into the VPU.
package vpu_uart_pkg;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // StSend covers the whole response; the serializer owns the SEND/SEND_WAIT handshake.
  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StGetCsum,
    StExec,
    StWaitRd,
    StSend
  } dec_state_e;

  typedef enum logic [1:0] {
    SerIdle,
    SerSend,
    SerWait
  } ser_state_e;

endpackage

// File: rtl/uart_resp_serializer.sv
// Shifts out a loaded response (1..DATA_BYTES+1 bytes, first byte in bits [7:0]) through the
// UART transmitter start/busy/done handshake.
module uart_resp_serializer
  import vpu_uart_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [8*(DATA_BYTES+1)-1:0]       load_bytes,
  input  logic [$clog2(DATA_BYTES+2)-1:0]   load_cnt,
  output logic [7:0]                        tx_data,
  output logic                              tx_en,
  input  logic                              tx_busy,
  input  logic                              tx_done,
  output logic                              done
);

  localparam int unsigned BufW = 8 * (DATA_BYTES + 1);
  localparam int unsigned CntW = $clog2(DATA_BYTES + 2);

  ser_state_e        state_q, state_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [CntW-1:0]   left_q, left_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SerIdle;
      buf_q   <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    left_d  = left_q;
    tx_en   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      SerIdle: begin
        if (load && load_cnt != '0) begin
          buf_d   = load_bytes;
          left_d  = load_cnt;
          state_d = SerSend;
        end
      end
      SerSend: begin
        if (!tx_busy) begin
          tx_en   = 1'b1;
          state_d = SerWait;
        end
      end
      SerWait: begin
        // tx_data stays on buf_q[7:0] until the transmitter reports the byte sent.
        if (tx_done) begin
          buf_d  = buf_q >> 8;
          left_d = left_q - CntW'(1);
          if (left_q == CntW'(1)) begin
            done    = 1'b1;
            state_d = SerIdle;
          end else begin
            state_d = SerSend;
          end
        end
      end
      default: state_d = SerIdle;
    endcase
  end

  assign tx_data = buf_q[7:0];

endmodule

// File: rtl/uart_cmd_decoder.sv
// Host command decoder: assembles read/write frames from UART bytes, checks the XOR checksum,
// issues single-cycle VPU register bus requests and answers with ACK/NAK plus read data.
module uart_cmd_decoder
  import vpu_uart_pkg::*;
#(
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  input  logic                    rx_parity_err,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy,
  input  logic                    tx_done,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  output logic                    bus_wr_en,
  output logic                    bus_rd_en,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  input  logic                    bus_rvalid,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned W    = 8 * DATA_BYTES;
  localparam int unsigned CntW = $clog2(DATA_BYTES + 2);
  localparam int unsigned IdxW = $clog2(DATA_BYTES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  dec_state_e        state_q, state_d;
  logic [7:0]        csum_q, csum_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              is_wr_q, is_wr_d;
  logic              match_q, match_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d, bus_addr_q, bus_addr_d;
  logic [W-1:0]      wdata_sh_q, wdata_sh_d, bus_wdata_q, bus_wdata_d;

  logic              rx_ok, rx_bad, send_nak, tmo_hit;
  logic              ser_load, ser_done;
  logic [W+7:0]      ser_bytes;
  logic [CntW-1:0]   ser_cnt;

  assign rx_ok   = rx_done & ~rx_parity_err;
  assign rx_bad  = rx_done & rx_parity_err;
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      csum_q      <= '0;
      tmo_q       <= '0;
      idx_q       <= '0;
      is_wr_q     <= 1'b0;
      match_q     <= 1'b0;
      addr_sh_q   <= '0;
      wdata_sh_q  <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      idx_q       <= idx_d;
      is_wr_q     <= is_wr_d;
      match_q     <= match_d;
      addr_sh_q   <= addr_sh_d;
      wdata_sh_q  <= wdata_sh_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    csum_d      = csum_q;
    tmo_d       = '0;
    idx_d       = idx_q;
    is_wr_d     = is_wr_q;
    match_d     = match_q;
    addr_sh_d   = addr_sh_q;
    wdata_sh_d  = wdata_sh_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wr_en   = 1'b0;
    bus_rd_en   = 1'b0;
    err         = 1'b0;
    send_nak    = 1'b0;
    ser_load    = 1'b0;
    ser_bytes   = {{W{1'b0}}, NAK};
    ser_cnt     = CntW'(1);

    // The idle counter only runs while a frame is partially received.
    if (state_q inside {StGetAddr, StGetData, StGetCsum}) begin
      tmo_d = rx_done ? '0 : tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        csum_d = '0;
        idx_d  = '0;
        if (rx_bad) begin
          send_nak = 1'b1;
        end else if (rx_ok) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            is_wr_d = (rx_data == OP_WR);
            csum_d  = rx_data;
            state_d = StGetAddr;
          end else begin
            send_nak = 1'b1;
          end
        end
      end
      StGetAddr: begin
        if (rx_bad) begin
          send_nak = 1'b1;
        end else if (rx_ok) begin
          addr_sh_d = rx_data[ADDR_W-1:0];
          csum_d    = csum_q ^ rx_data;
          state_d   = is_wr_q ? StGetData : StGetCsum;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StGetData: begin
        if (rx_bad) begin
          send_nak = 1'b1;
        end else if (rx_ok) begin
          // Bytes arrive LSB first, so shift in from the top.
          wdata_sh_d = (wdata_sh_q >> 8) | (W'(rx_data) << (W - 8));
          csum_d     = csum_q ^ rx_data;
          idx_d      = idx_q + IdxW'(1);
          if (idx_q == IdxW'(DATA_BYTES - 1)) state_d = StGetCsum;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StGetCsum: begin
        if (rx_bad) begin
          send_nak = 1'b1;
        end else if (rx_ok) begin
          match_d     = (rx_data == csum_q);
          bus_addr_d  = addr_sh_q;
          bus_wdata_d = wdata_sh_q;
          state_d     = StExec;
        end else if (tmo_hit) begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StExec: begin
        if (!match_q) begin
          send_nak = 1'b1;
        end else if (is_wr_q) begin
          bus_wr_en = 1'b1;
          ser_load  = 1'b1;
          ser_bytes = {{W{1'b0}}, ACK};
          state_d   = StSend;
        end else begin
          bus_rd_en = 1'b1;
          state_d   = StWaitRd;
        end
      end
      StWaitRd: begin
        if (bus_rvalid) begin
          ser_load  = 1'b1;
          ser_bytes = {bus_rdata, ACK};
          ser_cnt   = CntW'(DATA_BYTES + 1);
          state_d   = StSend;
        end
      end
      StSend: begin
        if (ser_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (send_nak) begin
      ser_load = 1'b1;
      err      = 1'b1;
      state_d  = StSend;
    end
    if (rx_done && (state_q inside {StExec, StWaitRd, StSend})) err = 1'b1;
  end

  uart_resp_serializer #(
    .DATA_BYTES (DATA_BYTES)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_bytes (ser_bytes),
    .load_cnt   (ser_cnt),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .done       (ser_done)
  );

  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder with a frame-level reference model and bus/UART responders.
module tb_uart_cmd_decoder;

  localparam int DB  = 4;
  localparam int AW  = 8;
  localparam int TMO = 64;
  localparam logic [7:0] B_OPW = 8'h57;
  localparam logic [7:0] B_OPR = 8'h52;
  localparam logic [7:0] B_ACK = 8'h06;
  localparam logic [7:0] B_NAK = 8'h15;

  logic          clk, rst;
  logic [7:0]    rx_data;
  logic          rx_done, rx_parity_err;
  logic [7:0]    tx_data;
  logic          tx_en, tx_busy, tx_done;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata, bus_rdata;
  logic          bus_wr_en, bus_rd_en, bus_rvalid;
  logic          busy, err;

  uart_cmd_decoder #(
    .DATA_BYTES  (DB),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .rx_parity_err (rx_parity_err),
    .tx_data       (tx_data),
    .tx_en         (tx_en),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wr_en     (bus_wr_en),
    .bus_rd_en     (bus_rd_en),
    .bus_rdata     (bus_rdata),
    .bus_rvalid    (bus_rvalid),
    .busy          (busy),
    .err           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cmp_cnt, fail_cnt;
  int err_cnt, wr_cnt, rd_cnt, proto_viol, rd_lat_fixed;
  logic [7:0]  tx_log[$];
  logic [7:0]  tx_hold;
  int          tx_cnt;
  logic [31:0] mem[256];
  bit          written[256];
  logic [31:0] ref_mem[256];
  logic [7:0]  last_wr_addr, rd_addr;
  logic [31:0] last_wr_data;
  logic        rd_pend;
  int          rd_wait;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // UART transmitter model: random busy time, one tx_done per accepted byte.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_cnt  <= 0;
    end else begin
      tx_done <= 1'b0;
      if (tx_en) begin
        if (tx_busy) proto_viol <= proto_viol + 1;
        tx_log.push_back(tx_data);
        tx_hold <= tx_data;
        tx_busy <= 1'b1;
        tx_cnt  <= $urandom_range(2, 6);
      end else if (tx_busy) begin
        if (tx_data !== tx_hold) proto_viol <= proto_viol + 1;
        if (tx_cnt == 1) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
        tx_cnt <= tx_cnt - 1;
      end
    end
  end

  // Register bus slave with variable read latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
      rd_pend    <= 1'b0;
      rd_wait    <= 0;
    end else begin
      bus_rvalid <= 1'b0;
      if (bus_wr_en) begin
        mem[bus_addr]     <= bus_wdata;
        written[bus_addr] <= 1'b1;
        wr_cnt            <= wr_cnt + 1;
        last_wr_addr      <= bus_addr;
        last_wr_data      <= bus_wdata;
      end
      if (bus_rd_en) begin
        rd_cnt  <= rd_cnt + 1;
        rd_pend <= 1'b1;
        rd_addr <= bus_addr;
        rd_wait <= (rd_lat_fixed > 0) ? rd_lat_fixed : $urandom_range(1, 5);
      end else if (rd_pend) begin
        if (rd_wait == 1) begin
          bus_rvalid <= 1'b1;
          bus_rdata  <= written[rd_addr] ? mem[rd_addr] : init_word(rd_addr);
          rd_pend    <= 1'b0;
        end
        rd_wait <= rd_wait - 1;
      end
    end
  end

  always @(posedge clk) if (!rst && err) err_cnt <= err_cnt + 1;

  // Frame under test, model predictions and observed deltas.
  logic [7:0]  frm[$];
  logic [7:0]  exp_resp[$];
  int          exp_wr, exp_rd, exp_err;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata;
  bit          obs_ok;
  int          obs_err, obs_wr, obs_rd;

  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02x ", q[i])};
    return s;
  endfunction

  function automatic bit same_resp();
    if (tx_log.size() != exp_resp.size()) return 1'b0;
    foreach (tx_log[i]) if (tx_log[i] !== exp_resp[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [7:0] xor_all(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  task automatic model_frame();
    int n;
    logic [31:0] d;
    exp_resp.delete();
    exp_wr = 0; exp_rd = 0; exp_err = 0;
    if (frm[0] != B_OPW && frm[0] != B_OPR) begin
      exp_resp.push_back(B_NAK);
      exp_err = 1;
      return;
    end
    n = (frm[0] == B_OPW) ? 3 + DB : 3;
    if (xor_all(frm[0:n-2]) != frm[n-1]) begin
      exp_resp.push_back(B_NAK);
      exp_err = 1;
    end else if (frm[0] == B_OPW) begin
      for (int k = 0; k < DB; k++) d[8*k +: 8] = frm[2+k];
      ref_mem[frm[1]] = d;
      exp_wr = 1; exp_addr = frm[1]; exp_wdata = d;
      exp_resp.push_back(B_ACK);
    end else begin
      d = ref_mem[frm[1]];
      exp_rd = 1;
      exp_resp.push_back(B_ACK);
      for (int k = 0; k < DB; k++) exp_resp.push_back(d[8*k +: 8]);
    end
  endtask

  task automatic build_write(input logic [7:0] a, input logic [31:0] d);
    frm.delete();
    frm.push_back(B_OPW);
    frm.push_back(a);
    for (int k = 0; k < DB; k++) frm.push_back(d[8*k +: 8]);
    frm.push_back(xor_all(frm));
  endtask

  task automatic build_read(input logic [7:0] a);
    frm.delete();
    frm.push_back(B_OPR);
    frm.push_back(a);
    frm.push_back(xor_all(frm));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic perr, input int gap);
    rx_data = b; rx_done = 1'b1; rx_parity_err = perr;
    @(negedge clk);
    rx_done = 1'b0; rx_parity_err = 1'b0; rx_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Sends frm (plus an optional byte dropped during execution) and records what happened.
  task automatic run_frame(input int gap, input bit extra);
    int e0, w0, r0;
    model_frame();
    tx_log.delete();
    e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
    foreach (frm[i]) send_byte(frm[i], 1'b0, gap);
    if (extra) send_byte(8'hAA, 1'b0, 0);
    wait_idle(obs_ok);
    obs_err = err_cnt - e0; obs_wr = wr_cnt - w0; obs_rd = rd_cnt - r0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({tx_en, tx_data, bus_addr, bus_wdata, bus_wr_en, bus_rd_en, busy, err} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got en=%b data=%02x addr=%02x wdata=%08x wr=%b rd=%b busy=%b err=%b, want all 0",
               tx_en, tx_data, bus_addr, bus_wdata, bus_wr_en, bus_rd_en, busy, err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_write();
    build_write(8'h10, 32'hDEADBEEF);
    run_frame(1, 1'b0);
    cmp_cnt++;
    if (!obs_ok || !same_resp()) begin
      fail_cnt++;
      $display("FAIL write_resp: got %s (idle=%0d) want %s", q2s(tx_log), obs_ok, q2s(exp_resp));
    end
    cmp_cnt++;
    if (obs_wr != 1 || obs_rd != 0 || obs_err != 0) begin
      fail_cnt++;
      $display("FAIL write_strobes: wr=%0d rd=%0d err=%0d want 1 0 0", obs_wr, obs_rd, obs_err);
    end
    cmp_cnt++;
    if (last_wr_addr !== 8'h10 || last_wr_data !== 32'hDEADBEEF || bus_wdata !== 32'hDEADBEEF) begin
      fail_cnt++;
      $display("FAIL write_bus: addr=%02x data=%08x hold=%08x want 10 deadbeef",
               last_wr_addr, last_wr_data, bus_wdata);
    end
  endtask

  task automatic test_read();
    build_write(8'h10, 32'h12345678);
    run_frame(0, 1'b0);
    rd_lat_fixed = 3;
    frm.delete();
    frm.push_back(8'h52); frm.push_back(8'h10); frm.push_back(8'h42);
    run_frame(2, 1'b0);
    rd_lat_fixed = 0;
    cmp_cnt++;
    if (!obs_ok || !same_resp()) begin
      fail_cnt++;
      $display("FAIL read_resp: got %s want %s", q2s(tx_log), q2s(exp_resp));
    end
    cmp_cnt++;
    if (obs_rd != 1 || obs_wr != 0 || obs_err != 0) begin
      fail_cnt++;
      $display("FAIL read_strobes: rd=%0d wr=%0d err=%0d want 1 0 0", obs_rd, obs_wr, obs_err);
    end
    cmp_cnt++;
    if (proto_viol != 0) begin
      fail_cnt++;
      $display("FAIL tx_handshake: violations=%0d want 0", proto_viol);
    end
  endtask

  task automatic test_bad_csum();
    build_write(8'h10, 32'hDEADBEEF);
    frm[frm.size()-1] = 8'h00;
    run_frame(0, 1'b0);
    cmp_cnt++;
    if (!same_resp() || obs_wr != 0 || obs_rd != 0 || obs_err != 1) begin
      fail_cnt++;
      $display("FAIL bad_csum: got %s wr=%0d rd=%0d err=%0d want %s 0 0 1",
               q2s(tx_log), obs_wr, obs_rd, obs_err, q2s(exp_resp));
    end
  endtask

  task automatic test_bad_opcode();
    frm.delete();
    frm.push_back(8'h41);
    run_frame(0, 1'b0);
    cmp_cnt++;
    if (!same_resp() || obs_err != 1) begin
      fail_cnt++;
      $display("FAIL bad_opcode: got %s err=%0d want %s 1", q2s(tx_log), obs_err, q2s(exp_resp));
    end
    build_read(8'h10);
    run_frame(0, 1'b0);
    cmp_cnt++;
    if (!same_resp() || obs_rd != 1 || obs_err != 0) begin
      fail_cnt++;
      $display("FAIL after_bad_opcode: got %s rd=%0d err=%0d want %s 1 0",
               q2s(tx_log), obs_rd, obs_err, q2s(exp_resp));
    end
  endtask

  task automatic test_parity();
    int e0;
    bit ok;
    tx_log.delete();
    e0 = err_cnt;
    send_byte(B_OPW, 1'b0, 0);
    send_byte(8'h10, 1'b1, 0);
    wait_idle(ok);
    exp_resp.delete();
    exp_resp.push_back(B_NAK);
    cmp_cnt++;
    if (!ok || !same_resp() || err_cnt - e0 != 1) begin
      fail_cnt++;
      $display("FAIL parity_abort: got %s err=%0d want %s 1", q2s(tx_log), err_cnt - e0, q2s(exp_resp));
    end
  endtask

  task automatic test_timeout();
    int e0;
    tx_log.delete();
    e0 = err_cnt;
    send_byte(B_OPW, 1'b0, 0);
    send_byte(8'h10, 1'b0, 0);
    repeat (TMO - 4) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b1 || err_cnt != e0) begin
      fail_cnt++;
      $display("FAIL timeout_early: busy=%b err=%0d want 1 0", busy, err_cnt - e0);
    end
    repeat (8) @(negedge clk);
    cmp_cnt++;
    if (busy !== 1'b0 || err_cnt - e0 != 1 || tx_log.size() != 0) begin
      fail_cnt++;
      $display("FAIL timeout_expire: busy=%b err=%0d tx=%0d want 0 1 0", busy, err_cnt - e0, tx_log.size());
    end
    build_write(8'h22, 32'hCAFE0123);
    run_frame(1, 1'b0);
    cmp_cnt++;
    if (!same_resp() || obs_wr != 1 || last_wr_data !== 32'hCAFE0123) begin
      fail_cnt++;
      $display("FAIL after_timeout: got %s wr=%0d data=%08x want %s 1 cafe0123",
               q2s(tx_log), obs_wr, last_wr_data, q2s(exp_resp));
    end
  endtask

  task automatic test_drop();
    build_read(8'h22);
    run_frame(0, 1'b1);
    cmp_cnt++;
    if (!same_resp() || obs_rd != 1 || obs_err != 1) begin
      fail_cnt++;
      $display("FAIL drop_byte: got %s rd=%0d err=%0d want %s 1 1", q2s(tx_log), obs_rd, obs_err, q2s(exp_resp));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      int kind;
      logic [7:0] a;
      kind = $urandom_range(0, 3);
      a    = 8'($urandom_range(0, 7));
      case (kind)
        0: build_write(a, $urandom);
        1: build_read(a);
        2: begin
          if ($urandom_range(0, 1) == 1) build_write(a, $urandom);
          else build_read(a);
          frm[frm.size()-1] ^= 8'($urandom_range(1, 255));
        end
        default: begin
          logic [7:0] op;
          do op = 8'($urandom); while (op == B_OPW || op == B_OPR);
          frm.delete();
          frm.push_back(op);
        end
      endcase
      run_frame($urandom_range(0, 2), 1'b0);
      cmp_cnt++;
      if (!obs_ok || !same_resp() || obs_wr != exp_wr || obs_rd != exp_rd || obs_err != exp_err) begin
        fail_cnt++;
        $display("FAIL random_%0d: frame %s got %s wr=%0d rd=%0d err=%0d want %s %0d %0d %0d",
                 n, q2s(frm), q2s(tx_log), obs_wr, obs_rd, obs_err, q2s(exp_resp), exp_wr, exp_rd, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    build_read(8'h05);
    model_frame();
    tx_log.delete();
    foreach (frm[i]) send_byte(frm[i], 1'b0, 0);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_log.size() >= 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (!seen) begin
      fail_cnt++;
      $display("FAIL reset_mid_setup: tx bytes=%0d want 2", tx_log.size());
    end
    rst = 1'b1;
    #1;
    cmp_cnt++;
    if ({tx_en, tx_data, bus_wr_en, bus_rd_en, busy, err} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_mid_outputs: en=%b data=%02x wr=%b rd=%b busy=%b err=%b want all 0",
               tx_en, tx_data, bus_wr_en, bus_rd_en, busy, err);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    cmp_cnt++;
    if (tx_log.size() != 2) begin
      fail_cnt++;
      $display("FAIL reset_mid_quiet: tx bytes=%0d want 2", tx_log.size());
    end
    build_read(8'h05);
    run_frame(1, 1'b0);
    cmp_cnt++;
    if (!obs_ok || !same_resp() || obs_rd != 1) begin
      fail_cnt++;
      $display("FAIL after_reset_read: got %s rd=%0d want %s 1", q2s(tx_log), obs_rd, q2s(exp_resp));
    end
  endtask

  initial begin
    rst = 1'b1;
    rx_data = 8'h00; rx_done = 1'b0; rx_parity_err = 1'b0;
    rd_lat_fixed = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    test_reset();
    test_write();
    test_read();
    test_bad_csum();
    test_bad_opcode();
    test_parity();
    test_timeout();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
